instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Initiator side of the instruction-memory port: owns the program counter, drives the single-cycle-latency, word-addressed instruction memory, and presents fetched instructions to decode through a valid/ready handshake. It sits between the branch/redirect logic and `instruction_memory`, absorbs decode back-pressure without losing or duplicating words, and flushes wrong-path fetches on redirect.

## Interface
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `fetch_en` input 1: when low, no new sequential requests are issued; the in-flight word is still delivered.
- `redirect_valid` input 1: one-cycle pulse; the next fetch comes from `redirect_pc`.
- `redirect_pc` input 32: redirect target, byte address; bits [1:0] are ignored.
- `imem_ce` output 1: memory chip enable.
- `imem_we` output 1: memory write enable; constant 0.
- `imem_addr` output 32: word address, `{2'b00, pc[31:2]}`.
- `imem_d` output 32: memory write data; constant 0.
- `imem_q` input 32: memory read data, valid the cycle after the address is presented with `imem_ce`=1.
- `out_valid` output 1: `out_instr`/`out_pc` hold a correct-path instruction.
- `out_ready` input 1: decode accepts the word this cycle when `out_valid` is also 1.
- `out_pc` output 32: byte address of `out_instr`.
- `out_instr` output 32: fetched instruction; passes `imem_q` through combinationally.

## Operation
- Registers:
  - `fetch_pc`: next PC to request.
  - `resp_pc`: PC whose data is on `imem_q` this cycle.
  - `resp_valid`: `resp_pc` is a real request.
- `imem_ce` = ~`rst`. It stays 1 outside reset because memory output is high-Z whenever ce=0.
- Outputs:
  - `out_valid` = `resp_valid` & ~`redirect_valid`.
  - `out_pc` = `resp_pc`.
  - `out_instr` = `imem_q`.
- `advance` = ~`resp_valid` | `out_ready`.
- Per-cycle priority, highest first:
  1. **rst**: `fetch_pc`←`RESET_PC`, `resp_pc`←`RESET_PC`, `resp_valid`←0.
  2. **redirect_valid**: `imem_addr`←target word. `resp_pc`←{`redirect_pc`[31:2],2'b00}, `resp_valid`←1, `fetch_pc`←that+4. The current word is dropped, even if `out_ready`=1.
  3. **advance & fetch_en**: `imem_addr`←`fetch_pc` word. `resp_pc`←`fetch_pc`, `resp_valid`←1, `fetch_pc`←`fetch_pc`+4.
  4. **advance & ~fetch_en**: `imem_addr`←`fetch_pc` word. `resp_valid`←0, `fetch_pc` holds.
  5. **stall** (`resp_valid` & ~`out_ready`): `imem_addr`←`resp_pc` word. This re-reads the same word so `imem_q` stays stable; all registers hold.
- PC arithmetic is mod 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Effective states:
  - RESET (`rst`).
  - EMPTY (`resp_valid`=0).
  - VALID (`resp_valid`=1, moving).
  - STALL (`resp_valid`=1, `out_ready`=0).
- Every instruction is delivered exactly once, in order, unless a redirect in the same cycle flushes it.

## Timing
- Reset values:
  - `out_valid`=0, `out_pc`=`RESET_PC`.
  - `imem_ce`=0, `imem_we`=0, `imem_d`=0.
  - `out_instr` is don't-care (Z).
- First cycle after `rst` falls: `imem_addr`=`RESET_PC`>>2, `out_valid`=0. The next cycle gives `out_valid`=1, `out_pc`=`RESET_PC`.
- Latency:
  - Sequential throughput is 1 word/cycle with `out_ready` held high.
  - Redirect-to-target output is 1 cycle.
- `imem_addr` has a combinational path from `out_ready` and `redirect_valid`. The memory samples it at the same edge, so there is no extra bubble.
- Reset mid-stall or mid-redirect: the pending word is discarded and the sequence restarts at `RESET_PC`.
- Redirect during a stall takes effect immediately; the stalled word is never delivered.
- `fetch_en` toggling never drops or duplicates the in-flight word.

## Structure
- Shared package:
  - `RESET_PC_DEFAULT`.
  - `INSTR_NOP` = 32'h0000_0013, used by decode for bubbles.
  - `PC_STEP` = 4.
  - Helper: byte-to-word-address conversion.
- No sub-module. It is a single flat block of roughly 150 lines; the memory is instantiated by the parent.

## Test plan
- Reset with `RESET_PC`=0, memory word i = 32'h1000_0000+i, `out_ready`=1 → outputs (pc,instr) = (0,0x10000000), (4,0x10000001), (8,0x10000002) on consecutive cycles.
- Drop `out_ready` for 3 cycles while `out_pc`=8 → `out_pc`=8 and `out_instr`=0x10000002 are held for all 3 cycles; after release, pc 12 follows with no gap or repeat.
- Pulse `redirect_valid` with `redirect_pc`=0x40 while `out_pc`=4 → `out_valid`=0 that cycle; the next cycle gives `out_pc`=0x40 with instr 0x10000010, then 0x44.
- Redirect with `redirect_pc`=0x43 during a stall → the stalled word is never accepted; the next output is `out_pc`=0x40.
- `fetch_en`=0 after the word at 8 is requested → pc 8 is delivered once, then `out_valid`=0; re-enable → the next output is pc 12.
- Assert `rst` mid-stream (`out_pc`=0x20) → `out_valid`=0 during reset and the cycle after; then `out_pc`=`RESET_PC`. `imem_we` is 0 throughout all tests.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants, types and helpers for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // EMPTY: no real request outstanding; VALID: imem_q carries the word at resp_pc.
    // STALL is VALID with out_ready low, so it needs no encoding of its own.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } fetch_state_t;

    // Byte address to memory word address.
    function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
        return {2'b00, byte_addr[31:2]};
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, drives the single-cycle instruction memory
// and hands fetched words to decode through a valid/ready handshake.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_ce,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_d,
    input  logic [31:0] imem_q,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    fetch_state_t state, state_next;
    logic [31:0]  fetch_pc, fetch_pc_next;
    logic [31:0]  resp_pc, resp_pc_next;
    logic [31:0]  req_pc;
    logic [31:0]  redirect_base;
    logic         resp_valid;
    logic         advance;

    assign resp_valid    = (state == ST_VALID);
    assign advance       = ~resp_valid | out_ready;
    assign redirect_base = redirect_pc & ~32'h0000_0003;

    // The memory tristates its output when disabled, so keep it enabled whenever out of reset.
    assign imem_ce   = ~rst;
    assign imem_we   = 1'b0;
    assign imem_d    = 32'h0000_0000;
    assign imem_addr = byte_to_word(req_pc);

    // Reset gating keeps a stale word from being offered while reset is held.
    assign out_valid = resp_valid & ~redirect_valid & ~rst;
    assign out_pc    = resp_pc;
    assign out_instr = imem_q;

    // State and PC registers with synchronous reset back to RESET_PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            resp_pc  <= resp_pc_next;
        end
    end

    // Request selection in priority order: redirect, sequential advance, idle advance, stall re-read.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        resp_pc_next  = resp_pc;
        req_pc        = resp_pc;
        if (redirect_valid) begin
            req_pc        = redirect_base;
            resp_pc_next  = redirect_base;
            fetch_pc_next = redirect_base + PC_STEP;
            state_next    = ST_VALID;
        end else if (advance && fetch_en) begin
            req_pc        = fetch_pc;
            resp_pc_next  = fetch_pc;
            fetch_pc_next = fetch_pc + PC_STEP;
            state_next    = ST_VALID;
        end else if (advance) begin
            req_pc     = fetch_pc;
            state_next = ST_EMPTY;
        end else begin
            req_pc = resp_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a single-cycle memory model.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_ce;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_d;
    logic [31:0] imem_q;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int checks = 0;
    int errors = 0;

    instruction_fetch #(.RESET_PC(RESET_PC_DEFAULT)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_ce        (imem_ce),
        .imem_we        (imem_we),
        .imem_addr      (imem_addr),
        .imem_d         (imem_d),
        .imem_q         (imem_q),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: word i holds 0x10000000+i, read data one cycle after the address, Z when disabled.
    always @(posedge clk) begin
        imem_q <= imem_ce ? (32'h1000_0000 + imem_addr) : 32'hzzzz_zzzz;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Wait for a clock edge, drive one cycle's inputs, then let the combinational outputs settle.
    task automatic applyStimulus(input logic r, input logic en, input logic rdy,
                                 input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst            = r;
        fetch_en       = en;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        checkOutput("imem_we", {31'b0, imem_we}, 32'h0);
    endtask

    task automatic checkBeat(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        checkOutput({tag, ".valid"}, {31'b0, out_valid}, 32'h1);
        checkOutput({tag, ".pc"}, out_pc, pc);
        checkOutput({tag, ".instr"}, out_instr, instr);
    endtask

    task automatic checkBubble(input string tag);
        checkOutput({tag, ".valid"}, {31'b0, out_valid}, 32'h0);
    endtask

    // Linear sequence of directed cycles; each step lists the expected outputs of that cycle.
    initial begin
        rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;

        applyStimulus(1, 1, 1, 0, 32'h0);
        checkBubble("reset");
        checkOutput("reset.ce", {31'b0, imem_ce}, 32'h0);
        checkOutput("reset.d", imem_d, 32'h0);

        applyStimulus(0, 1, 1, 0, 32'h0);
        checkBubble("first");
        checkOutput("first.pc", out_pc, 32'h0);
        checkOutput("first.ce", {31'b0, imem_ce}, 32'h1);
        checkOutput("first.addr", imem_addr, 32'h0);

        applyStimulus(0, 1, 1, 0, 32'h0);
        checkBeat("seq0", 32'h0, 32'h1000_0000);
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkBeat("seq4", 32'h4, 32'h1000_0001);

        applyStimulus(0, 1, 0, 0, 32'h0);
        checkBeat("stall1", 32'h8, 32'h1000_0002);
        checkOutput("stall1.addr", imem_addr, 32'h2);
        applyStimulus(0, 1, 0, 0, 32'h0);
        checkBeat("stall2", 32'h8, 32'h1000_0002);
        applyStimulus(0, 1, 0, 0, 32'h0);
        checkBeat("stall3", 32'h8, 32'h1000_0002);
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkBeat("release", 32'h8, 32'h1000_0002);
        checkOutput("release.addr", imem_addr, 32'h3);
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkBeat("after_stall", 32'hC, 32'h1000_0003);

        applyStimulus(0, 1, 1, 1, 32'h40);
        checkBubble("redir");
        checkOutput("redir.addr", imem_addr, 32'h10);
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkBeat("redir_tgt", 32'h40, 32'h1000_0010);

        applyStimulus(0, 1, 0, 0, 32'h0);
        checkBeat("stall_pre", 32'h44, 32'h1000_0011);
        applyStimulus(0, 1, 0, 1, 32'h43);
        checkBubble("stall_redir");
        checkOutput("stall_redir.addr", imem_addr, 32'h10);
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkBeat("stall_redir_tgt", 32'h40, 32'h1000_0010);
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkBeat("stall_redir_next", 32'h44, 32'h1000_0011);

        applyStimulus(0, 0, 1, 0, 32'h0);
        checkBeat("fen_off", 32'h48, 32'h1000_0012);
        checkOutput("fen_off.addr", imem_addr, 32'h13);
        applyStimulus(0, 0, 1, 0, 32'h0);
        checkBubble("fen_idle");
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkBubble("fen_on");
        checkOutput("fen_on.addr", imem_addr, 32'h13);
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkBeat("fen_resume", 32'h4C, 32'h1000_0013);

        applyStimulus(1, 1, 1, 0, 32'h0);
        checkBubble("mid_reset");
        checkOutput("mid_reset.ce", {31'b0, imem_ce}, 32'h0);
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkBubble("post_reset");
        checkOutput("post_reset.pc", out_pc, RESET_PC_DEFAULT);
        checkOutput("post_reset.addr", imem_addr, 32'h0);
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkBeat("restart", 32'h0, 32'h1000_0000);

        applyStimulus(0, 1, 1, 1, 32'hFFFF_FFFC);
        checkBubble("wrap_redir");
        checkOutput("wrap_redir.addr", imem_addr, 32'h3FFF_FFFF);
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkBeat("wrap_top", 32'hFFFF_FFFC, 32'h4FFF_FFFF);
        applyStimulus(0, 1, 1, 0, 32'h0);
        checkBeat("wrap_zero", 32'h0, 32'h1000_0000);
        checkOutput("wrap_zero.addr", imem_addr, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
